// File: rtl/ttc_pkg.sv
// Shared types and defaults for the exhaustive truth-table sweep checker.
package ttc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } ttc_state_t;

  localparam int N_IN_DEFAULT   = 4;
  localparam int SETTLE_DEFAULT = 2;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/truth_table_capture_first_set_idx.sv
// Priority encoder: index of the lowest set bit of vec, plus a valid flag.
module first_set_idx #(
  parameter int W  = 16,
  parameter int IW = 4
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          vld
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/truth_table_capture.sv
// Drives every input vector of a small combinational DUT, captures its output
// into a truth table, then compares against an expected table.
module truth_table_capture
  import ttc_pkg::*;
#(
  parameter int N_IN   = N_IN_DEFAULT,
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_y,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_count,
  output logic [N_IN-1:0]      first_fail_idx,
  output logic                 fail_valid
);

  localparam int DEPTH = 2**N_IN;

  ttc_state_t         state_q, state_d;
  logic [N_IN-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]   exp_q, exp_d;
  logic [DEPTH-1:0]   table_q, table_d;
  logic               pass_q, pass_d;
  logic [N_IN:0]      mcnt_q, mcnt_d;
  logic [N_IN-1:0]    ffi_q, ffi_d;
  logic               fval_q, fval_d;

  logic [DEPTH-1:0]   diff;
  logic [N_IN:0]      popcnt;
  logic [N_IN-1:0]    enc_idx;
  logic               enc_vld;
  logic               accept;
  logic               sample;

  assign diff   = table_q ^ exp_q;
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign sample = (state_q == RUN) && (cnt_q == CNT_W'(SETTLE));

  first_set_idx #(
    .W  (DEPTH),
    .IW (N_IN)
  ) u_first_set_idx (
    .vec (diff),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      popcnt = popcnt + {{N_IN{1'b0}}, diff[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      pass_q  <= 1'b0;
      mcnt_q  <= '0;
      ffi_q   <= '0;
      fval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      pass_q  <= pass_d;
      mcnt_q  <= mcnt_d;
      ffi_q   <= ffi_d;
      fval_q  <= fval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (sample && (idx_q == '1)) state_d = CHECK;
      CHECK:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath: sweep counters, table capture and result registration.
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    table_d = table_q;
    pass_d  = pass_q;
    mcnt_d  = mcnt_q;
    ffi_d   = ffi_q;
    fval_d  = fval_q;

    if (accept) begin
      idx_d   = '0;
      cnt_d   = '0;
      exp_d   = expected;
      table_d = '0;
      pass_d  = 1'b0;
      mcnt_d  = '0;
      ffi_d   = '0;
      fval_d  = 1'b0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (sample) begin
        table_d[idx_q] = dut_y;
        cnt_d          = '0;
        if (idx_q != '1) idx_d = idx_q + N_IN'(1);
      end
    end else if (state_q == CHECK) begin
      pass_d = ~enc_vld;
      mcnt_d = popcnt;
      ffi_d  = enc_idx;
      fval_d = enc_vld;
    end
  end

  always_comb begin
    dut_in         = (state_q == RUN) ? idx_q : '0;
    busy           = (state_q == RUN) || (state_q == CHECK);
    done           = (state_q == DONE);
    table_out      = table_q;
    pass           = pass_q;
    mismatch_count = mcnt_q;
    first_fail_idx = ffi_q;
    fail_valid     = fval_q;
  end

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: SETTLE=2 and SETTLE=0 instances, random
// expected tables and glitch timing checked against a table-level model.
module tb_truth_table_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start2 = 1'b0, start0 = 1'b0;
  logic [15:0] exp2 = '0, exp0 = '0;
  logic        y2 = 1'b0, y0;
  logic [3:0]  dut_in2, dut_in0;
  logic        busy2, busy0, done2, done0;
  logic [15:0] table2, table0;
  logic        pass2, pass0;
  logic [4:0]  mc2, mc0;
  logic [3:0]  ff2, ff0;
  logic        fv2, fv0;

  int n_chk = 0;
  int n_err = 0;
  int cur_sel = 2;
  int fn0 = 0;

  truth_table_capture #(.N_IN(4), .SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .expected(exp2), .dut_y(y2),
    .dut_in(dut_in2), .busy(busy2), .done(done2), .table_out(table2),
    .pass(pass2), .mismatch_count(mc2), .first_fail_idx(ff2), .fail_valid(fv2)
  );

  truth_table_capture #(.N_IN(4), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .expected(exp0), .dut_y(y0),
    .dut_in(dut_in0), .busy(busy0), .done(done0), .table_out(table0),
    .pass(pass0), .mismatch_count(mc0), .first_fail_idx(ff0), .fail_valid(fv0)
  );

  function automatic logic f_gtue(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  function automatic logic f_lab0(input logic [3:0] v, input int fn);
    return (fn == 0) ? v[0] : ^v;
  endfunction

  // Slow lab circuit: output lags its inputs by one cycle.
  always @(posedge clk) y2 <= f_gtue(dut_in2);
  always_comb y0 = f_lab0(dut_in0, fn0);

  logic [3:0]  o_dut_in;
  logic        o_busy, o_done, o_pass, o_fv;
  logic [15:0] o_table;
  logic [4:0]  o_mc;
  logic [3:0]  o_ff;
  always_comb begin
    o_dut_in = (cur_sel == 2) ? dut_in2 : dut_in0;
    o_busy   = (cur_sel == 2) ? busy2   : busy0;
    o_done   = (cur_sel == 2) ? done2   : done0;
    o_table  = (cur_sel == 2) ? table2  : table0;
    o_pass   = (cur_sel == 2) ? pass2   : pass0;
    o_mc     = (cur_sel == 2) ? mc2     : mc0;
    o_ff     = (cur_sel == 2) ? ff2     : ff0;
    o_fv     = (cur_sel == 2) ? fv2     : fv0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_table(input int sel);
    logic [15:0] t;
    logic [3:0]  v;
    t = '0;
    for (int k = 0; k < 16; k++) begin
      v = k[3:0];
      t[k] = (sel == 2) ? f_gtue(v) : f_lab0(v, fn0);
    end
    return t;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 2) start2 = v; else start0 = v;
  endtask

  task automatic set_exp(input int sel, input logic [15:0] v);
    if (sel == 2) exp2 = v; else exp0 = v;
  endtask

  // One full sweep; glitch_j >= 0 pulses start and scrambles expected mid-run.
  task automatic sweep(input int sel, input logic [15:0] expv, input int glitch_j, input string tag);
    int s, run_len, lat, bad, mc, ff, exp_idx;
    logic [15:0] tbl, diff;
    s       = (sel == 2) ? 2 : 0;
    run_len = 16 * (s + 1);
    tbl     = ref_table(sel);
    diff    = tbl ^ expv;
    mc = 0; ff = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) begin mc++; ff = i; end
    cur_sel = sel;
    @(negedge clk);
    set_exp(sel, expv);
    set_start(sel, 1'b1);
    @(posedge clk);
    lat = -1; bad = 0;
    for (int j = 0; j < 300 && lat < 0; j++) begin
      @(negedge clk);
      if (j == 0) set_start(sel, 1'b0);
      if (glitch_j >= 0 && j == glitch_j) begin
        set_start(sel, 1'b1);
        set_exp(sel, ~expv);
      end
      if (glitch_j >= 0 && j == glitch_j + 2) set_start(sel, 1'b0);
      exp_idx = (j < run_len) ? j / (s + 1) : 0;
      if (o_dut_in !== exp_idx[3:0]) bad++;
      if (o_busy !== (j <= run_len)) bad++;
      if (o_done) lat = j + 1;
    end
    check({tag, "_finished"}, 32'(lat >= 0), 32'd1);
    check({tag, "_seq"}, bad, 0);
    check({tag, "_done_lat"}, lat, run_len + 2);
    check({tag, "_table"}, o_table, tbl);
    check({tag, "_pass"}, o_pass, 32'(diff == 16'h0));
    check({tag, "_mcount"}, o_mc, mc);
    check({tag, "_ffidx"}, o_ff, ff);
    check({tag, "_fvalid"}, o_fv, 32'(diff != 16'h0));
    @(negedge clk);
    check({tag, "_held"}, {o_done, o_busy, o_table}, {1'b1, 1'b0, tbl});
  endtask

  task automatic reset_mid_sweep(input logic [15:0] expv);
    int found;
    cur_sel = 2;
    @(negedge clk);
    exp2 = expv; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    found = 0;
    for (int j = 0; j < 100 && found == 0; j++) begin
      if (dut_in2 == 4'd7) found = 1;
      else @(negedge clk);
    end
    check("rst_reached_vec7", found, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_ctrl", {dut_in2, busy2, done2, pass2, mc2, ff2, fv2}, 32'h0);
    check("rst_async_table", table2, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_idle_after", {busy2, done2, dut_in2}, 32'h0);
  endtask

  initial begin
    logic [15:0] e;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_ctrl2", {dut_in2, busy2, done2, pass2, mc2, ff2, fv2}, 32'h0);
    check("idle_table2", table2, 16'h0);
    check("idle_ctrl0", {dut_in0, busy0, done0, pass0, fv0, table0}, 32'h0);

    sweep(2, 16'hF888, -1, "gtue_pass");
    sweep(2, 16'hF88C, -1, "gtue_onefail");
    reset_mid_sweep(16'hF888);
    sweep(2, 16'hF888, -1, "after_rst");
    sweep(2, 16'hF888, 20, "glitch_pass");

    for (int r = 0; r < 4; r++) begin
      e = ref_table(2);
      if (r[0]) e = e ^ 16'($urandom);
      else e = e ^ (16'h1 << $urandom_range(15, 0));
      sweep(2, e, $urandom_range(40, 1), "rand2");
    end

    fn0 = 0;
    sweep(0, 16'hAAAA, -1, "s0_first");
    sweep(0, 16'hAAAA, -1, "s0_from_done");
    fn0 = 1;
    sweep(0, ref_table(0), -1, "s0_parity_pass");
    for (int r = 0; r < 3; r++) begin
      sweep(0, 16'($urandom), $urandom_range(12, 1), "rand0");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/truth_table_capture.md
# truth_table_capture

Synthesizable exhaustive-sweep checker for small combinational lab designs. On `start` it drives every input combination of an N-input device under test in ascending binary order, holds each vector for a programmable settle time, and samples the DUT's single-bit output into a truth-table register. After the sweep it compares the table against an expected table and reports pass/fail, the mismatch count and the first failing index. It sits beside the lab circuits on the board and replaces hand-written exhaustive stimulus benches.

## Interface
Parameters:
- `N_IN`, 4: number of DUT inputs; table depth `2**N_IN`.
- `SETTLE`, 2: extra cycles each vector is held before sampling; range 0..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE and DONE.
- `expected`  in  2**N_IN  expected truth table, bit k = y for input k; latched on accepted start.
- `dut_y`  in  1  DUT output.
- `dut_in`  out  N_IN  vector driven to the DUT, MSB = first DUT input.
- `busy`  out  1  high during RUN and CHECK.
- `done`  out  1  high while in DONE.
- `table_out`  out  2**N_IN  captured truth table.
- `pass`  out  1  table_out == latched expected; valid while done.
- `mismatch_count`  out  N_IN+1  popcount of table_out XOR expected.
- `first_fail_idx`  out  N_IN  lowest mismatching index; 0 if none.
- `fail_valid`  out  1  at least one mismatch.

## Operation
- States: IDLE, RUN, CHECK, DONE.
- IDLE: `start`=1 → latch `expected`, clear table and results, idx=0, settle count=0, go RUN.
- RUN: `dut_in`=idx. Settle count increments every cycle; when count==SETTLE, write `dut_y` to `table_out[idx]` and reset count. If idx==2**N_IN-1 go CHECK, else idx+1.
- CHECK (one cycle): register pass, mismatch_count, first_fail_idx, fail_valid from the final table; go DONE.
- DONE: results and table held. `start`=1 → restart exactly as from IDLE (clears results). Otherwise stay.
- `start` in RUN/CHECK is ignored; changes to `expected` after the accepted start are ignored.
- `dut_in` returns to 0 in CHECK, DONE and IDLE.
- Reset (at any time, including mid-sweep): state IDLE; `dut_in`=0, `busy`=0, `done`=0, `table_out`=0, `pass`=0, `mismatch_count`=0, `first_fail_idx`=0, `fail_valid`=0. A partial sweep is discarded.

## Timing
- Each vector is driven for exactly SETTLE+1 cycles; `dut_y` is sampled on the last edge of that window.
- Start accepted at edge E → RUN from E+1; last sample at edge E + 2**N_IN·(SETTLE+1); CHECK for the next cycle; `done` high from edge E + 2**N_IN·(SETTLE+1) + 2.
- Defaults: `done` rises 50 cycles after the accepted start.
- SETTLE=0: a new vector every cycle; sampled on the edge ending its single cycle.
- `dut_y` must be stable (combinational DUT) within one cycle of `dut_in` changing; the settle window covers slower paths.

## Structure
- Shared package `ttc_pkg`: state enum `ttc_state_t` {IDLE, RUN, CHECK, DONE}, default `N_IN` and `SETTLE` constants.
- One sub-module: `first_set_idx`, a parameterized priority encoder (lowest set bit index plus valid) applied to table_out XOR expected. Popcount stays inline.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `dut_in`=0, `busy`=0.
- DUT model y=(g&t)|(u&e), `expected`=16'hF888, SETTLE=2 → `dut_in` steps 0..15 at 3 cycles each, `done` at start+50, `table_out`=16'hF888, `pass`=1, `mismatch_count`=0, `fail_valid`=0.
- Same DUT, `expected`=16'hF88C → `pass`=0, `mismatch_count`=1, `first_fail_idx`=2, `fail_valid`=1.
- Assert `rst` during vector 7 → all outputs 0 immediately. Then `start` → a clean full sweep with correct results.
- Pulse `start` during RUN, and change `expected` mid-sweep → ignored; `done` time and results unchanged.
- SETTLE=0, y=e (expected 16'hAAAA): `start` from DONE → new value every cycle, `done` at start+18, `pass`=1.
